// File: rtl/debounce_scheduler.sv
// debounce_scheduler: N switch channels, each with a 2-flop synchronizer and an
// early-debounce FSM sharing one sample tick. Every debounced level change is
// recorded as a pending event, and a round-robin arbiter forwards pending events
// to a valid/ready event port. A sticky ovf flag records lost events.
// Optional build macro: DEBOUNCE_SCHEDULER_FIFO_EN selects a 4-entry event FIFO
// instead of the default single output register.
module debounce_scheduler #(
  parameter int N          = 4,
  parameter int TICK_M     = 2_000_000,
  parameter int LOCK_TICKS = 2,
  localparam int CW        = $clog2(N),
  localparam int TCW       = $clog2(TICK_M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  sw,
  output logic [N-1:0]  db,
  output logic          ev_valid,
  input  logic          ev_ready,
  output logic [CW-1:0] ev_chan,
  output logic          ev_level,
  output logic          ovf,
  input  logic          ovf_clr
);

  // Encoding chosen so that bit 0 is the debounced level.
  localparam logic [1:0] ST_ZERO  = 2'b00;
  localparam logic [1:0] ST_WAIT1 = 2'b01;
  localparam logic [1:0] ST_ONE   = 2'b11;
  localparam logic [1:0] ST_WAIT0 = 2'b10;
  localparam logic [3:0] LK_LOAD  = 4'(LOCK_TICKS);

  logic [N-1:0]   r_sync1;
  logic [N-1:0]   r_sync2;
  logic [TCW-1:0] r_cnt;
  logic           w_tick;
  logic [1:0]     r_state    [N];
  logic [3:0]     r_lk       [N];
  logic [1:0]     w_state_nx [N];
  logic [3:0]     w_lk_nx    [N];
  logic [N-1:0]   w_db_nx;
  logic [N-1:0]   w_chg;
  logic [N-1:0]   r_pend;
  logic [N-1:0]   r_plev;
  logic [CW-1:0]  r_ptr;
  logic           w_can_grant;
  logic           w_grant_vld;
  logic [CW-1:0]  w_grant_idx;
  logic           w_grant_lev;
  logic [N-1:0]   w_gnt;
  logic           w_pop;
  logic           w_loss;

  // Wrap-around channel index used by the round-robin search.
  function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int offs);
    int j;
    j = int'(base) + offs;
    if (j >= N) begin
      j = j - N;
    end else begin
      j = j;
    end
    return CW'(j);
  endfunction

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_cnt == TCW'(TICK_M - 1));

  // Shared free-running sample-tick counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TCW'(1);
    end
  end

  // FSM state register and lock counters for every channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= ST_ZERO;
        r_lk[i]    <= 4'd0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= w_state_nx[i];
        r_lk[i]    <= w_lk_nx[i];
      end
    end
  end

  // Next-state logic: react at once to an edge, then ignore the input until the lock expires.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_state_nx[i] = r_state[i];
      w_lk_nx[i]    = r_lk[i];
      case (r_state[i])
        ST_ZERO: begin
          if (r_sync2[i]) begin
            w_state_nx[i] = ST_WAIT1;
            w_lk_nx[i]    = LK_LOAD;
          end else begin
            w_state_nx[i] = ST_ZERO;
          end
        end
        ST_ONE: begin
          if (!r_sync2[i]) begin
            w_state_nx[i] = ST_WAIT0;
            w_lk_nx[i]    = LK_LOAD;
          end else begin
            w_state_nx[i] = ST_ONE;
          end
        end
        ST_WAIT1: begin
          if (w_tick && (r_lk[i] <= 4'd1)) begin
            if (r_sync2[i]) begin
              w_state_nx[i] = ST_ONE;
              w_lk_nx[i]    = 4'd0;
            end else begin
              w_state_nx[i] = ST_WAIT0;
              w_lk_nx[i]    = LK_LOAD;
            end
          end else if (w_tick) begin
            w_lk_nx[i] = r_lk[i] - 4'd1;
          end else begin
            w_lk_nx[i] = r_lk[i];
          end
        end
        ST_WAIT0: begin
          if (w_tick && (r_lk[i] <= 4'd1)) begin
            if (!r_sync2[i]) begin
              w_state_nx[i] = ST_ZERO;
              w_lk_nx[i]    = 4'd0;
            end else begin
              w_state_nx[i] = ST_WAIT1;
              w_lk_nx[i]    = LK_LOAD;
            end
          end else if (w_tick) begin
            w_lk_nx[i] = r_lk[i] - 4'd1;
          end else begin
            w_lk_nx[i] = r_lk[i];
          end
        end
        default: begin
          w_state_nx[i] = ST_ZERO;
          w_lk_nx[i]    = 4'd0;
        end
      endcase
    end
  end

  // Output decode: debounced level now and after this edge, and change detect.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      db[i]      = r_state[i][0];
      w_db_nx[i] = w_state_nx[i][0];
      w_chg[i]   = w_state_nx[i][0] ^ r_state[i][0];
    end
  end

  // Round-robin search over pending channels, starting after the last grant.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_grant_vld && w_can_grant && r_pend[rr_idx(r_ptr, k)]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = rr_idx(r_ptr, k);
      end else begin
        w_grant_vld = w_grant_vld;
      end
    end
    w_grant_lev = r_plev[w_grant_idx];
    for (int i = 0; i < N; i++) begin
      w_gnt[i] = w_grant_vld && (w_grant_idx == CW'(i));
    end
  end

  // An event is lost when a change hits a pending slot that is not leaving this cycle.
  assign w_loss = |(w_chg & r_pend & ~w_gnt);

  // Pending flags, pending levels, arbiter pointer and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend <= '0;
      r_plev <= '0;
      r_ptr  <= '0;
      ovf    <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_chg[i]) begin
          r_pend[i] <= 1'b1;
          r_plev[i] <= w_db_nx[i];
        end else if (w_gnt[i]) begin
          r_pend[i] <= 1'b0;
        end else begin
          r_pend[i] <= r_pend[i];
        end
      end
      if (w_grant_vld) begin
        r_ptr <= (w_grant_idx == CW'(N - 1)) ? '0 : (w_grant_idx + CW'(1));
      end else begin
        r_ptr <= r_ptr;
      end
      if (w_loss) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end else begin
        ovf <= ovf;
      end
    end
  end

`ifdef DEBOUNCE_SCHEDULER_FIFO_EN
  logic [CW-1:0] r_fifo_chan [4];
  logic [3:0]    r_fifo_lev;
  logic [1:0]    r_wr;
  logic [1:0]    r_rd;
  logic [2:0]    r_count;

  assign ev_valid    = (r_count != 3'd0);
  assign ev_chan     = r_fifo_chan[r_rd];
  assign ev_level    = r_fifo_lev[r_rd];
  assign w_pop       = ev_valid && ev_ready;
  assign w_can_grant = (r_count != 3'd4) || w_pop;

  // Four-entry event FIFO fed by the arbiter and drained by the consumer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < 4; e++) begin
        r_fifo_chan[e] <= '0;
      end
      r_fifo_lev <= 4'd0;
      r_wr       <= 2'd0;
      r_rd       <= 2'd0;
      r_count    <= 3'd0;
    end else begin
      if (w_grant_vld) begin
        r_fifo_chan[r_wr] <= w_grant_idx;
        r_fifo_lev[r_wr]  <= w_grant_lev;
        r_wr              <= r_wr + 2'd1;
      end else begin
        r_wr <= r_wr;
      end
      if (w_pop) begin
        r_rd <= r_rd + 2'd1;
      end else begin
        r_rd <= r_rd;
      end
      case ({w_grant_vld, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  logic          r_ev_valid;
  logic [CW-1:0] r_ev_chan;
  logic          r_ev_level;

  assign ev_valid    = r_ev_valid;
  assign ev_chan     = r_ev_chan;
  assign ev_level    = r_ev_level;
  assign w_pop       = r_ev_valid && ev_ready;
  assign w_can_grant = !r_ev_valid || ev_ready;

  // Single event output register, held stable until accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ev_valid <= 1'b0;
      r_ev_chan  <= '0;
      r_ev_level <= 1'b0;
    end else if (w_grant_vld) begin
      r_ev_valid <= 1'b1;
      r_ev_chan  <= w_grant_idx;
      r_ev_level <= w_grant_lev;
    end else if (w_pop) begin
      r_ev_valid <= 1'b0;
    end else begin
      r_ev_valid <= r_ev_valid;
    end
  end
`endif

endmodule

// File: tb/tb_debounce_scheduler.sv
// Bench for debounce_scheduler: directed vector table, hand-written corner
// sequences, then randomized stimulus against a behavioural reference model.
module tb_debounce_scheduler;

  localparam int N      = 4;
  localparam int TICK_M = 4;
  localparam int LOCK   = 2;
`ifdef DEBOUNCE_SCHEDULER_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic [3:0] db;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_chan;
  logic       ev_level;
  logic       ovf;
  logic       ovf_clr;

  int n_checks = 0;
  int n_errors = 0;

  debounce_scheduler #(.N(N), .TICK_M(TICK_M), .LOCK_TICKS(LOCK)) dut (
    .clk(clk), .reset(reset), .sw(sw), .db(db),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_chan(ev_chan),
    .ev_level(ev_level), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed { logic [1:0] ch; logic lv; } ev_t;
  ev_t        m_q[$];
  logic [3:0] m_sync1, m_s, m_db, m_pend, m_plev;
  int         m_lock[N];
  int         m_cnt, m_ptr;
  logic       m_ovf;

  task automatic model_reset();
    m_q.delete();
    m_sync1 = '0; m_s = '0; m_db = '0; m_pend = '0; m_plev = '0;
    m_cnt = 0; m_ptr = 0; m_ovf = 1'b0;
    for (int i = 0; i < N; i++) m_lock[i] = 0;
  endtask

  // Level follows the input immediately when unlocked; a lock of LOCK ticks
  // follows every change; on expiry the level re-follows the input.
  task automatic model_step(input logic [3:0] sw_in, input logic rdy, input logic clr);
    logic       tick, pop, cang, loss;
    logic [3:0] newdb;
    int         g;
    tick  = (m_cnt == TICK_M - 1);
    newdb = m_db;
    for (int i = 0; i < N; i++) begin
      if (m_lock[i] == 0) begin
        if (m_s[i] != m_db[i]) begin newdb[i] = m_s[i]; m_lock[i] = LOCK; end
      end else if (tick) begin
        m_lock[i]--;
        if (m_lock[i] == 0 && m_s[i] != m_db[i]) begin newdb[i] = m_s[i]; m_lock[i] = LOCK; end
      end
    end
    pop  = (m_q.size() > 0) && rdy;
    cang = (m_q.size() < CAP) || pop;
    g = -1;
    if (cang) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(ev_t'{ch: 2'(g), lv: m_plev[g]});
      m_ptr = (g + 1) % N;
    end
    loss = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (newdb[i] != m_db[i]) begin
        if (m_pend[i] && g != i) loss = 1'b1;
        m_pend[i] = 1'b1;
        m_plev[i] = newdb[i];
      end else if (g == i) begin
        m_pend[i] = 1'b0;
      end
    end
    m_db = newdb;
    if (loss) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_s = m_sync1;
    m_sync1 = sw_in;
    m_cnt = tick ? 0 : m_cnt + 1;
  endtask

  // ---------------- helpers ----------------
  task automatic do_reset();
    reset = 1'b1; sw = 4'b0; ev_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_db", 32'(db), 32'd0);
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_chan", 32'(ev_chan), 32'd0);
    chk("rst_level", 32'(ev_level), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct packed {
    logic [3:0] sw; logic rdy; logic [3:0] db; logic v; logic [1:0] ch; logic lv;
  } vec_t;
  vec_t tbl[16];

  int   ev_cnt;
  ev_t  exp_ev;
  logic [3:0] rsw;
  logic       rrdy, rclr;
  int   rdy_pct;
  logic [1:0] exp_order[5];

  initial begin
    // row k: inputs applied before clk edge k+1, outputs expected after it
    tbl[0]  = '{4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    tbl[4]  = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0};
    tbl[5]  = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0};
    tbl[6]  = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0};
    tbl[7]  = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[11] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0};
    tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0};
    tbl[13] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0};
    tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};

    // ---- table-driven single-channel rise/fall ----
    do_reset();
    for (int k = 0; k < 16; k++) begin
      sw = tbl[k].sw; ev_ready = tbl[k].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_db", k), 32'(db), 32'(tbl[k].db));
      chk($sformatf("tbl%0d_valid", k), 32'(ev_valid), 32'(tbl[k].v));
      if (tbl[k].v) begin
        chk($sformatf("tbl%0d_chan", k), 32'(ev_chan), 32'(tbl[k].ch));
        chk($sformatf("tbl%0d_level", k), 32'(ev_level), 32'(tbl[k].lv));
      end
    end

    // ---- all channels rise together: events 0,1,2,3 back to back ----
    do_reset();
    sw = 4'b1111; ev_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("all_db", 32'(db), 32'hf);
    chk("all_nov", 32'(ev_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("all_valid%0d", k), 32'(ev_valid), 32'd1);
      chk($sformatf("all_chan%0d", k), 32'(ev_chan), 32'(k));
      chk($sformatf("all_level%0d", k), 32'(ev_level), 32'd1);
    end
    @(negedge clk);
    chk("all_done", 32'(ev_valid), 32'd0);

    // ---- fast toggling of channel 1 ----
    do_reset();
    ev_ready = 1'b1; ev_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      sw[1] = (c < 20) ? ~sw[1] : 1'b0;
      @(negedge clk);
      if (ev_valid && ev_ready) ev_cnt++;
      if (ev_valid && ev_chan != 2'd1) chk("tog_chan", 32'(ev_chan), 32'd1);
    end
    chk("tog_db", 32'(db), 32'd0);
    chk("tog_even", 32'(ev_cnt % 2), 32'd0);
    chk("tog_some", 32'(ev_cnt >= 2), 32'd1);
    chk("tog_ovf", 32'(ovf), 32'd0);
    chk("tog_idle", 32'(ev_valid), 32'd0);

    // ---- backpressure, pending, overflow and clear ----
    do_reset();
    sw = 4'b1111; ev_ready = 1'b0;
    repeat (12) @(negedge clk);
    chk("bp_head", 32'(ev_chan), 32'd0);
    sw[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("bp_noovf", 32'(ovf), 32'd0);
    chk("bp_valid", 32'(ev_valid), 32'd1);
    chk("bp_hold_chan", 32'(ev_chan), 32'd0);
    chk("bp_hold_level", 32'(ev_level), 32'd1);
    sw[0] = 1'b1;
    repeat (20) @(negedge clk);
    chk("bp_ovf", 32'(ovf), 32'd1);
    chk("bp_hold_chan2", 32'(ev_chan), 32'd0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("bp_ovf_clr", 32'(ovf), 32'd0);
    exp_order[0] = 2'd0; exp_order[1] = 2'd1; exp_order[2] = 2'd2;
    exp_order[3] = 2'd3; exp_order[4] = 2'd0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("drain_valid%0d", k), 32'(ev_valid), 32'd1);
      chk($sformatf("drain_chan%0d", k), 32'(ev_chan), 32'(exp_order[k]));
      chk($sformatf("drain_level%0d", k), 32'(ev_level), 32'd1);
      ev_ready = 1'b1;
      @(negedge clk);
    end
    chk("drain_empty", 32'(ev_valid), 32'd0);

    // ---- reset mid-lock with events queued ----
    do_reset();
    sw = 4'b0110; ev_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_valid", 32'(ev_valid), 32'd1);
    #2 reset = 1'b1; sw = 4'b0;
    #1 chk("mid_async_db", 32'(db), 32'd0);
    @(negedge clk);
    chk("mid_db", 32'(db), 32'd0);
    chk("mid_nov", 32'(ev_valid), 32'd0);
    chk("mid_ovf", 32'(ovf), 32'd0);
    reset = 1'b0; ev_ready = 1'b1; ev_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (ev_valid) ev_cnt++;
    end
    chk("mid_no_event", 32'(ev_cnt), 32'd0);

    // ---- randomized run against the reference model ----
    do_reset();
    rsw = 4'b0;
    for (int c = 0; c < 3000; c++) begin
      rdy_pct = ((c / 300) % 2 == 0) ? 80 : 15;
      if ($urandom_range(0, 99) < ((c / 150) % 3 == 1 ? 60 : 10))
        rsw[$urandom_range(0, N - 1)] = ~rsw[$urandom_range(0, N - 1)];
      rrdy = ($urandom_range(0, 99) < rdy_pct);
      rclr = ($urandom_range(0, 39) == 0);
      sw = rsw; ev_ready = rrdy; ovf_clr = rclr;
      model_step(rsw, rrdy, rclr);
      @(negedge clk);
      chk("rnd_db", 32'(db), 32'(m_db));
      chk("rnd_valid", 32'(ev_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        exp_ev = m_q[0];
        chk("rnd_chan", 32'(ev_chan), 32'(exp_ev.ch));
        chk("rnd_level", 32'(ev_level), 32'(exp_ev.lv));
      end
      chk("rnd_ovf", 32'(ovf), 32'(m_ovf));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
